// File: rtl/input_debouncer.sv
// Per-channel two-flop synchronizer plus persistence counter; a new level is
// accepted only after it has been seen DEBOUNCE_CYCLES enabled edges in a row.

module input_debouncer_lane #(
    parameter int   CW       = 16,
    parameter int   LAST_CNT = 0,
    parameter logic RST_BIT  = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_raw,
    output logic o_sync2,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall
);
    localparam logic [CW-1:0] W_LAST = LAST_CNT[CW-1:0];

    logic          r_sync1;
    logic          r_sync2;
    logic          r_clean;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= RST_BIT;
            r_sync2 <= RST_BIT;
            r_clean <= RST_BIT;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            // Any return to the accepted level restarts the count.
            if (!i_en || (r_sync2 == r_clean)) begin
                r_cnt <= '0;
            end else if (r_cnt == W_LAST) begin
                r_clean <= r_sync2;
                r_cnt   <= '0;
                r_rise  <= r_sync2;
                r_fall  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_sync2 = r_sync2;
    assign o_clean = r_clean;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
endmodule

module input_debouncer #(
    parameter int               WIDTH           = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             stable
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] w_sync2;

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_lane
            input_debouncer_lane #(
                .CW      (CW),
                .LAST_CNT(DEBOUNCE_CYCLES - 1),
                .RST_BIT (RESET_VAL[g])
            ) u_lane (
                .i_clk  (clk),
                .i_rst  (rst),
                .i_en   (en),
                .i_raw  (raw_in[g]),
                .o_sync2(w_sync2[g]),
                .o_clean(clean_out[g]),
                .o_rise (rise[g]),
                .o_fall (fall[g])
            );
        end
    endgenerate

    assign stable = &(w_sync2 ~^ clean_out);
endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: two instances (RESET_VAL 00 and 11) share stimulus
// and are checked each edge against a sliding-window model.

module tb_input_debouncer;
    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [1:0] raw = 2'b00;

    logic [1:0] o_clean [2];
    logic [1:0] o_rise  [2];
    logic [1:0] o_fall  [2];
    logic       o_stable[2];

    always #5 clk = ~clk;

    input_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(DC), .RESET_VAL(2'b00)) u_d0 (
        .clk(clk), .rst(rst), .en(en), .raw_in(raw),
        .clean_out(o_clean[0]), .rise(o_rise[0]), .fall(o_fall[0]), .stable(o_stable[0]));

    input_debouncer #(.WIDTH(2), .DEBOUNCE_CYCLES(DC), .RESET_VAL(2'b11)) u_d1 (
        .clk(clk), .rst(rst), .en(en), .raw_in(raw),
        .clean_out(o_clean[1]), .rise(o_rise[1]), .fall(o_fall[1]), .stable(o_stable[1]));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: sync2 is raw delayed two edges; a bit is accepted when the last DC
    // edges were all enabled and all saw sync2 differing from the accepted level.
    logic [1:0] m_s1[2], m_s2[2], m_clean[2], m_rise[2], m_fall[2];
    logic [1:0] h_s2[2][DC];
    logic       h_en[2][DC];
    int         h_n[2];

    function automatic logic [1:0] rv(input int d);
        return (d == 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [1:0] x);
        for (int d = 0; d < 2; d++) begin
            m_rise[d] = 2'b00;
            m_fall[d] = 2'b00;
            if (r) begin
                m_s1[d] = rv(d); m_s2[d] = rv(d); m_clean[d] = rv(d); h_n[d] = 0;
            end else begin
                for (int j = DC - 1; j > 0; j--) begin
                    h_s2[d][j] = h_s2[d][j-1];
                    h_en[d][j] = h_en[d][j-1];
                end
                h_s2[d][0] = m_s2[d];
                h_en[d][0] = e;
                if (h_n[d] < DC) h_n[d]++;
                for (int ch = 0; ch < 2; ch++) begin
                    logic ok;
                    ok = (h_n[d] == DC);
                    for (int j = 0; j < DC; j++)
                        ok = ok && h_en[d][j] && (h_s2[d][j][ch] != m_clean[d][ch]);
                    if (ok) begin
                        m_clean[d][ch] = h_s2[d][0][ch];
                        m_rise[d][ch]  = h_s2[d][0][ch];
                        m_fall[d][ch]  = ~h_s2[d][0][ch];
                    end
                end
                m_s2[d] = m_s1[d];
                m_s1[d] = x;
            end
        end
    endtask

    int tcount = 0;

    task automatic tick();
        logic c_rst, c_en;
        logic [1:0] c_raw;
        c_rst = rst; c_en = en; c_raw = raw;
        @(posedge clk);
        #1;
        tcount++;
        model_step(c_rst, c_en, c_raw);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("m%0d_clean", d), 32'(o_clean[d]), 32'(m_clean[d]));
            chk($sformatf("m%0d_rise", d), 32'(o_rise[d]), 32'(m_rise[d]));
            chk($sformatf("m%0d_fall", d), 32'(o_fall[d]), 32'(m_fall[d]));
            chk($sformatf("m%0d_stable", d), 32'(o_stable[d]), 32'(m_s2[d] == m_clean[d]));
        end
    endtask

    task automatic do_reset(input logic [1:0] x);
        rst = 1'b1; en = 1'b1; raw = x;
        tick();
        rst = 1'b0;
    endtask

    // Tick until the selected instance shows a nonzero rise/fall; dly counts edges.
    task automatic wait_pulse(input int d, input logic is_fall, input int budget,
                              output int dly, output logic [1:0] val);
        dly = 0; val = 2'b00;
        for (int i = 1; i <= budget; i++) begin
            tick();
            val = is_fall ? o_fall[d] : o_rise[d];
            if (val != 2'b00) begin
                dly = i;
                break;
            end
        end
        if (dly == 0) begin
            failures++;
            $display("FAIL wait_pulse_timeout dut=%0d fall=%0b", d, is_fall);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] raw;
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
        logic       stable;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int dly;
        int nrise;
        int t_final;
        int t_rise;
        logic [1:0] val;
        logic [1:0] pat[6];
        logic bad;

        tbl[0] = '{1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1};
        tbl[7] = '{1'b0, 1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1};

        for (int i = 0; i < 8; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; raw = tbl[i].raw;
            tick();
            chk($sformatf("tbl%0d_clean", i), 32'(o_clean[0]), 32'(tbl[i].clean));
            chk($sformatf("tbl%0d_rise", i), 32'(o_rise[0]), 32'(tbl[i].rise));
            chk($sformatf("tbl%0d_fall", i), 32'(o_fall[0]), 32'(tbl[i].fall));
            chk($sformatf("tbl%0d_stable", i), 32'(o_stable[0]), 32'(tbl[i].stable));
        end

        // Bounce on bit 0
        do_reset(2'b00);
        pat = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01};
        nrise = 0; t_final = 0; t_rise = 0;
        for (int i = 0; i < 6; i++) begin
            raw = pat[i];
            tick();
            if (i == 5) t_final = tcount;
            if (o_rise[0][0]) begin nrise++; if (t_rise == 0) t_rise = tcount; end
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            if (o_rise[0][0]) begin nrise++; if (t_rise == 0) t_rise = tcount; end
        end
        chk("bounce_delay", 32'(t_rise - t_final + 1), 32'd6);
        chk("bounce_nrise", 32'(nrise), 32'd1);

        // Both channels together
        do_reset(2'b00);
        raw = 2'b11;
        wait_pulse(0, 1'b0, 12, dly, val);
        chk("both_rise_val", 32'(val), 32'h3);
        chk("both_rise_dly", 32'(dly), 32'd6);
        for (int i = 0; i < 3; i++) tick();
        raw = 2'b00;
        wait_pulse(0, 1'b1, 12, dly, val);
        chk("both_fall_val", 32'(val), 32'h3);
        chk("both_fall_dly", 32'(dly), 32'd6);

        // Reset mid-count
        do_reset(2'b00);
        raw = 2'b10;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        chk("midrst_clean", 32'(o_clean[0]), 32'h0);
        chk("midrst_pulse", 32'({o_rise[0], o_fall[0]}), 32'h0);
        rst = 1'b0;
        wait_pulse(0, 1'b0, 12, dly, val);
        chk("midrst_val", 32'(val), 32'h2);
        chk("midrst_dly", 32'(dly), 32'd6);

        // Enable gating
        do_reset(2'b00);
        en = 1'b0; raw = 2'b01;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_clean[0] != 2'b00 || o_rise[0] != 2'b00 || o_fall[0] != 2'b00) bad = 1'b1;
        end
        chk("en_gate_quiet", 32'(bad), 32'd0);
        chk("en_gate_stable", 32'(o_stable[0]), 32'd0);
        en = 1'b1;
        wait_pulse(0, 1'b0, 12, dly, val);
        chk("en_rise_val", 32'(val), 32'h1);
        chk("en_rise_dly", 32'(dly), 32'd4);
        chk("en_clean", 32'(o_clean[0]), 32'h1);

        // RESET_VAL=11 instance with raw low at reset
        do_reset(2'b00);
        chk("rv11_clean_rst", 32'(o_clean[1]), 32'h3);
        wait_pulse(1, 1'b1, 12, dly, val);
        chk("rv11_fall_val", 32'(val), 32'h3);
        chk("rv11_fall_dly", 32'(dly), 32'd6);
        tick();
        chk("rv11_fall_once", 32'(o_fall[1]), 32'h0);
        chk("rv11_stable", 32'(o_stable[1]), 32'd1);

        // Randomized segments
        do_reset(2'b00);
        for (int s = 0; s < 400; s++) begin
            int hold;
            raw  = 2'($urandom);
            hold = int'($urandom_range(1, 8));
            for (int i = 0; i < hold; i++) begin
                en  = ($urandom_range(0, 9) != 0);
                rst = ($urandom_range(0, 79) == 0);
                tick();
            end
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
